// File: rtl/if_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | if_stage_pkg : shared RISC-V widths, NOP encoding and fetch-queue entry type
// | Rev 1.0
// +----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int unsigned c_XLEN = 64;
  localparam int unsigned c_ILEN = 32;
  localparam logic [31:0] c_NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_ILEN-1:0] inst;
    logic              filled;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | if_stage_fetch_queue : in-order queue of outstanding fetches (alloc/fill/deq)
// | Rev 1.0
// +----------------------------------------------------------------------------
module if_stage_fetch_queue
  import if_stage_pkg::*;
#(
  parameter int FQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_i,
  input  logic [c_XLEN-1:0]         alloc_pc_i,
  input  logic                      fill_i,
  input  logic [c_ILEN-1:0]         fill_inst_i,
  input  logic                      deq_i,
  input  logic                      flush_i,
  output logic [$clog2(FQ_DEPTH):0] count_o,
  output logic [$clog2(FQ_DEPTH):0] unfilled_count_o,
  output fq_entry_t                 head_o
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t       entry_q [FQ_DEPTH];
  logic [PW-1:0]   alloc_ptr_q;
  logic [PW-1:0]   fill_ptr_q;
  logic [PW-1:0]   head_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   unfilled_q;

  // Entries head..fill-1 are filled, fill..alloc-1 await data; the top never
  // allocates into a full queue, so alloc and fill never target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        entry_q[i] <= '{pc: '0, inst: c_NOP, filled: 1'b0};
      end
    end else if (flush_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        entry_q[i].filled <= 1'b0;
      end
    end else begin
      if (alloc_i) begin
        entry_q[alloc_ptr_q].pc     <= alloc_pc_i;
        entry_q[alloc_ptr_q].filled <= 1'b0;
        alloc_ptr_q                 <= alloc_ptr_q + PW'(1);
      end
      if (fill_i) begin
        entry_q[fill_ptr_q].inst   <= fill_inst_i;
        entry_q[fill_ptr_q].filled <= 1'b1;
        fill_ptr_q                 <= fill_ptr_q + PW'(1);
      end
      if (deq_i) begin
        head_ptr_q <= head_ptr_q + PW'(1);
      end
      count_q    <= count_q + CW'(alloc_i) - CW'(deq_i);
      unfilled_q <= unfilled_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign count_o          = count_q;
  assign unfilled_count_o = unfilled_q;
  assign head_o           = entry_q[head_ptr_q];

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | if_stage : RV64 fetch stage - PC, request gating, stale-response drop, redirect
// | Rev 1.0
// +----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int          CW         = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] c_FQ_DEPTH = (CW+1)'(FQ_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fq_count;
  logic [CW-1:0] fq_unfilled;
  fq_entry_t     fq_head;
  logic          accept;
  logic          fill;
  logic          deq;
  logic [CW:0]   slots_used;

  // Stale in-flight responses still hold a slot until they come back.
  assign slots_used     = {1'b0, fq_count} + {1'b0, drop_cnt_q};
  assign imem_req_valid = !rst && !redirect_valid && (slots_used < c_FQ_DEPTH);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign id_valid = (fq_count != '0) && fq_head.filled;
  assign id_pc    = fq_head.pc;
  assign id_inst  = fq_head.inst;
  assign deq      = id_valid && id_ready && !redirect_valid;
  assign fill     = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[63:2], 2'b00};
      drop_cnt_d = drop_cnt_q + fq_unfilled - CW'(imem_resp_valid);
    end else begin
      if (accept) begin
        pc_d = pc_q + 64'd4;
      end
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  if_stage_fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk              (clk),
    .rst              (rst),
    .alloc_i          (accept),
    .alloc_pc_i       (pc_q),
    .fill_i           (fill),
    .fill_inst_i      (imem_resp_data),
    .deq_i            (deq),
    .flush_i          (redirect_valid),
    .count_o          (fq_count),
    .unfilled_count_o (fq_unfilled),
    .head_o           (fq_head)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_resp_valid && (drop_cnt_q == '0) && (fq_unfilled == '0)))
        else $error("if_stage: memory response with no outstanding request");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_if_stage : randomized bench for if_stage against an epoch/scoreboard model
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_if_stage;

  localparam int          D   = 4;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RPC), .FQ_DEPTH(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_inst         (id_inst)
  );

  // Memory requests remember the fetch epoch they were issued in; a redirect
  // starts a new epoch, so anything older is discarded when it returns.
  typedef struct { logic [63:0] addr; logic [31:0] data; int epoch; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } instr_t;

  mreq_t       mem_q[$];
  instr_t      sb[$];
  logic [63:0] acc_log[$];
  logic [63:0] xfer_log[$];
  int          epoch = 0;
  logic [63:0] exp_pc = RPC;
  int          n_chk = 0;
  int          n_pass = 0;

  int          p_rdy = 100, p_resp = 100, p_idr = 100, p_redir = 0;
  bit          force_rst = 1'b1, force_redir = 1'b0, rnd_rst = 1'b0;
  logic [63:0] force_pc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    bit     exp_rv;
    mreq_t  r;
    @(negedge clk);
    rst             = force_rst || (rnd_rst && ($urandom_range(299) == 0));
    imem_req_ready  = ($urandom_range(99) < p_rdy);
    if (mem_q.size() > 0 && $urandom_range(99) < p_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_q[0].data;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    id_ready       = ($urandom_range(99) < p_idr);
    redirect_valid = force_redir || ($urandom_range(999) < p_redir);
    redirect_pc    = force_redir ? force_pc : {$urandom, $urandom};
    #1;
    exp_rv = !rst && !redirect_valid && ((mem_q.size() + sb.size()) < D);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, exp_pc);
    check("id_valid", id_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      check("id_pc", id_pc, sb[0].pc);
      check("id_inst", id_inst, sb[0].inst);
    end
    if (rst) begin
      mem_q.delete();
      sb.delete();
      exp_pc = RPC;
      epoch++;
    end else begin
      if (sb.size() > 0 && id_ready && !redirect_valid) begin
        xfer_log.push_back(sb[0].pc);
        void'(sb.pop_front());
      end
      if (imem_resp_valid) begin
        r = mem_q.pop_front();
        if (r.epoch == epoch && !redirect_valid) sb.push_back('{r.addr, r.data});
      end
      if (redirect_valid) begin
        sb.delete();
        epoch++;
        exp_pc = redirect_pc & ~64'h3;
      end else if (exp_rv && imem_req_ready) begin
        mem_q.push_back('{exp_pc, $urandom, epoch});
        acc_log.push_back(exp_pc);
        exp_pc = exp_pc + 64'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    acc_log.delete();
    xfer_log.delete();
  endtask

  initial begin
    repeat (3) step();
    #1;
    check("rst_id_pc", id_pc, 64'h0);
    check("rst_id_inst", id_inst, 64'h13);
    force_rst = 1'b0;

    // Streaming at one instruction per cycle
    acc_log.delete(); xfer_log.delete();
    repeat (12) step();
    check("t1_first_addr", acc_log[0], RPC);
    check("t1_addr3", acc_log[3], RPC + 64'd12);
    check("t1_first_id_pc", xfer_log[0], RPC);
    check("t1_xfer_count", xfer_log.size(), 10);

    // Decode stalled: queue fills, then drains in order
    do_reset();
    p_idr = 0;
    repeat (10) step();
    check("t2_accepts", acc_log.size(), 4);
    p_idr = 100;
    repeat (8) step();
    check("t2_order3", xfer_log[3], RPC + 64'd12);
    check("t2_resume", acc_log[4], RPC + 64'd16);

    // Redirect with two requests in flight
    do_reset();
    p_resp = 0;
    repeat (2) step();
    force_redir = 1'b1; force_pc = 64'h0000_0000_8000_1002;
    step();
    force_redir = 1'b0; p_resp = 100;
    acc_log.delete(); xfer_log.delete();
    repeat (8) step();
    check("t3_addr", acc_log[0], 64'h0000_0000_8000_1000);
    check("t3_first_id_pc", xfer_log[0], 64'h0000_0000_8000_1000);

    // Redirect coinciding with a response and a dequeue
    do_reset();
    repeat (6) step();
    force_redir = 1'b1; force_pc = 64'h0000_0000_8000_2000;
    step();
    force_redir = 1'b0;
    xfer_log.delete();
    repeat (6) step();
    check("t4_first_id_pc", xfer_log[0], 64'h0000_0000_8000_2000);

    // Memory back-pressure
    do_reset();
    p_rdy = 0;
    repeat (4) step();
    check("t5_no_accept", acc_log.size(), 0);
    p_rdy = 100;
    repeat (3) step();
    check("t5_first_addr", acc_log[0], RPC);

    // Reset with a full queue
    do_reset();
    p_idr = 0;
    repeat (8) step();
    force_rst = 1'b1;
    repeat (2) step();
    force_rst = 1'b0; p_idr = 100;
    acc_log.delete();
    step();
    check("t6_first_addr", acc_log[0], RPC);

    // Random traffic, redirects and resets
    p_rdy = 70; p_resp = 60; p_idr = 65; p_redir = 30; rnd_rst = 1'b1;
    repeat (3000) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
